// File: rtl/itch_order_parser_pkg.sv
// Shared constants and types for the ITCH 5.0 order-event parser.
package itch_order_parser_pkg;

  typedef enum logic [1:0] {LEN_HI, LEN_LO, MSG} parserStateType;

  // Message type bytes and the buy-side marker
  localparam logic [7:0] ITCH_ADD      = 8'h41;  // 'A'
  localparam logic [7:0] ITCH_ADD_MPID = 8'h46;  // 'F'
  localparam logic [7:0] ITCH_DEL      = 8'h44;  // 'D'
  localparam logic [7:0] ITCH_EXEC     = 8'h45;  // 'E'
  localparam logic [7:0] ITCH_SIDE_BUY = 8'h42;  // 'B'

  // Expected message lengths, type byte included
  localparam logic [15:0] ITCH_ADD_LEN      = 16'd36;
  localparam logic [15:0] ITCH_ADD_MPID_LEN = 16'd40;
  localparam logic [15:0] ITCH_DEL_LEN      = 16'd19;
  localparam logic [15:0] ITCH_EXEC_LEN     = 16'd31;

  // Byte offsets within a message (inclusive ranges)
  localparam logic [15:0] OFF_LOC_LO      = 16'd1;
  localparam logic [15:0] OFF_LOC_HI      = 16'd2;
  localparam logic [15:0] OFF_REF_LO      = 16'd11;
  localparam logic [15:0] OFF_REF_HI      = 16'd18;
  localparam logic [15:0] OFF_ADD_SIDE    = 16'd19;
  localparam logic [15:0] OFF_ADD_SHR_LO  = 16'd20;
  localparam logic [15:0] OFF_ADD_SHR_HI  = 16'd23;
  localparam logic [15:0] OFF_ADD_PRC_LO  = 16'd32;
  localparam logic [15:0] OFF_ADD_PRC_HI  = 16'd35;
  localparam logic [15:0] OFF_EXEC_SHR_LO = 16'd19;
  localparam logic [15:0] OFF_EXEC_SHR_HI = 16'd22;

  // True when byte index idx falls in [lo, hi]
  function automatic logic in_span(input logic [15:0] idx, input logic [15:0] lo,
                                   input logic [15:0] hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/itch_order_parser_if.sv
// Byte-stream input and decoded order-event output bundle of the parser.
interface itch_order_parser_if #(
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     dataValidIn;
  logic                     dataLastIn;
  logic [7:0]               dataIn;
  logic                     addValidOut;
  logic                     delValidOut;
  logic                     execValidOut;
  logic [63:0]              refNumOut;
  logic [15:0]              locateOut;
  logic [31:0]              priceOut;
  logic [31:0]              sharesOut;
  logic                     buySellOut;
  logic [ERR_CNT_WIDTH-1:0] errCountOut;

  // Stream source / event consumer side
  modport master (
    output dataValidIn, dataLastIn, dataIn,
    input  addValidOut, delValidOut, execValidOut, refNumOut, locateOut,
           priceOut, sharesOut, buySellOut, errCountOut
  );

  // Parser side
  modport slave (
    input  dataValidIn, dataLastIn, dataIn,
    output addValidOut, delValidOut, execValidOut, refNumOut, locateOut,
           priceOut, sharesOut, buySellOut, errCountOut
  );
endinterface

// File: rtl/itch_order_parser.sv
// ITCH 5.0 message-block parser: walks {len, msg} blocks one byte per valid
// cycle and emits registered add/delete/execute pulses with their fields.
module itch_order_parser
  import itch_order_parser_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 16,
  parameter int SUPPORT_MPID  = 1
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  itch_order_parser_if.slave   bus
);

  localparam logic MPID_EN = (SUPPORT_MPID != 0);

  parserStateType           state_q, state_d;
  logic [15:0]              idx_q, idx_d, len_q, len_d;
  logic [7:0]               type_q, type_d;
  // shadow field registers filled as bytes stream past
  logic [15:0]              loc_q, loc_d;
  logic [63:0]              ref_q, ref_d;
  logic [31:0]              price_q, price_d, shares_q, shares_d;
  logic                     side_q, side_d;
  // registered outputs
  logic                     add_q, add_d, del_q, del_d, exec_q, exec_d;
  logic [15:0]              loco_q, loco_d;
  logic [63:0]              refo_q, refo_d;
  logic [31:0]              priceo_q, priceo_d, shareso_q, shareso_d;
  logic                     buyo_q, buyo_d;
  logic [ERR_CNT_WIDTH-1:0] err_q, err_d;

  logic [7:0]  cur_type;
  logic        is_add, is_del, is_exec, last_byte, err_inc;
  logic [15:0] exp_len;

  // State, shadow and output registers; reset also suppresses a due pulse
  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state_q  <= LEN_HI;   idx_q     <= '0; len_q  <= '0; type_q <= '0;
      loc_q    <= '0;       ref_q     <= '0; price_q <= '0; shares_q <= '0; side_q <= 1'b0;
      add_q    <= 1'b0;     del_q     <= 1'b0; exec_q <= 1'b0;
      loco_q   <= '0;       refo_q    <= '0;
      priceo_q <= '0;       shareso_q <= '0; buyo_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;  idx_q     <= idx_d; len_q <= len_d; type_q <= type_d;
      loc_q    <= loc_d;    ref_q     <= ref_d; price_q <= price_d; shares_q <= shares_d;
      side_q   <= side_d;
      add_q    <= add_d;    del_q     <= del_d; exec_q <= exec_d;
      loco_q   <= loco_d;   refo_q    <= refo_d;
      priceo_q <= priceo_d; shareso_q <= shareso_d; buyo_q <= buyo_d;
      err_q    <= err_d;
    end
  end

  // Next state: length capture, offset-indexed field shifts, end-of-message verdict
  always_comb begin
    state_d   = state_q;  idx_d    = idx_q;    len_d    = len_q;   type_d = type_q;
    loc_d     = loc_q;    ref_d    = ref_q;    price_d  = price_q;
    shares_d  = shares_q; side_d   = side_q;
    add_d     = 1'b0;     del_d    = 1'b0;     exec_d   = 1'b0;
    loco_d    = loco_q;   refo_d   = refo_q;
    priceo_d  = priceo_q; shareso_d = shareso_q; buyo_d = buyo_q;
    err_inc   = 1'b0;

    // On byte 0 the type is still on the bus, not yet latched
    cur_type  = (idx_q == '0) ? bus.dataIn : type_q;
    is_add    = (cur_type == ITCH_ADD) || (MPID_EN && (cur_type == ITCH_ADD_MPID));
    is_del    = (cur_type == ITCH_DEL);
    is_exec   = (cur_type == ITCH_EXEC);
    exp_len   = is_add  ? ((cur_type == ITCH_ADD) ? ITCH_ADD_LEN : ITCH_ADD_MPID_LEN) :
                is_del  ? ITCH_DEL_LEN :
                is_exec ? ITCH_EXEC_LEN : '0;
    last_byte = (idx_q == (len_q - 16'd1));

    if (bus.dataValidIn) begin
      case (state_q)
        LEN_HI: begin
          len_d = {bus.dataIn, len_q[7:0]};
          if (bus.dataLastIn) err_inc = 1'b1;
          else                state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = {len_q[15:8], bus.dataIn};
          idx_d = '0;
          if (bus.dataLastIn) begin
            err_inc = 1'b1;
            state_d = LEN_HI;
          end else if (len_d == '0) begin
            state_d = LEN_HI;
          end else begin
            state_d = MSG;
          end
        end
        MSG: begin
          if (idx_q == '0) type_d = bus.dataIn;
          if (in_span(idx_q, OFF_LOC_LO, OFF_LOC_HI)) loc_d = {loc_q[7:0], bus.dataIn};
          if (in_span(idx_q, OFF_REF_LO, OFF_REF_HI)) ref_d = {ref_q[55:0], bus.dataIn};
          if (is_add) begin
            if (idx_q == OFF_ADD_SIDE) side_d = (bus.dataIn == ITCH_SIDE_BUY);
            if (in_span(idx_q, OFF_ADD_SHR_LO, OFF_ADD_SHR_HI))
              shares_d = {shares_q[23:0], bus.dataIn};
            if (in_span(idx_q, OFF_ADD_PRC_LO, OFF_ADD_PRC_HI))
              price_d = {price_q[23:0], bus.dataIn};
          end else if (is_exec) begin
            if (in_span(idx_q, OFF_EXEC_SHR_LO, OFF_EXEC_SHR_HI))
              shares_d = {shares_q[23:0], bus.dataIn};
          end

          if (last_byte) begin
            state_d = LEN_HI;
            idx_d   = '0;
            if (is_add || is_del || is_exec) begin
              if (len_q == exp_len) begin
                add_d     = is_add;
                del_d     = is_del;
                exec_d    = is_exec;
                loco_d    = loc_d;
                refo_d    = ref_d;
                priceo_d  = is_add ? price_d : '0;
                shareso_d = (is_add || is_exec) ? shares_d : '0;
                buyo_d    = is_add & side_d;
              end else begin
                err_inc = 1'b1;
              end
            end
          end else if (bus.dataLastIn) begin
            // payload ended mid-message
            err_inc = 1'b1;
            state_d = LEN_HI;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end
        default: state_d = LEN_HI;
      endcase
    end

    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_CNT_WIDTH'(1) : err_q;
  end

  assign bus.addValidOut  = add_q;
  assign bus.delValidOut  = del_q;
  assign bus.execValidOut = exec_q;
  assign bus.refNumOut    = refo_q;
  assign bus.locateOut    = loco_q;
  assign bus.priceOut     = priceo_q;
  assign bus.sharesOut    = shareso_q;
  assign bus.buySellOut   = buyo_q;
  assign bus.errCountOut  = err_q;

endmodule

// File: tb/tb_itch_order_parser.sv
// Scoreboard bench for itch_order_parser: builds ITCH messages from field
// values, queues the expected events and compares them as pulses appear.
module tb_itch_order_parser;

  logic clkIn = 1'b0;
  logic rstIn = 1'b0;
  always #5 clkIn = ~clkIn;

  itch_order_parser_if #(.ERR_CNT_WIDTH(16)) bus();

  itch_order_parser #(.ERR_CNT_WIDTH(16), .SUPPORT_MPID(1)) dut (
    .clkIn (clkIn),
    .rstIn (rstIn),
    .bus   (bus)
  );

  localparam logic [2:0] K_ADD = 3'b100, K_DEL = 3'b010, K_EXEC = 3'b001, K_NONE = 3'b000;

  typedef struct {
    logic [2:0]  kind;
    logic [63:0] rn;
    logic [15:0] loc;
    logic [31:0] prc;
    logic [31:0] shr;
    logic        side;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_e;
  logic [7:0] mbuf [0:63];
  int         total = 0;
  int         bad   = 0;
  int         exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every pulse against the head of the scoreboard
  always @(negedge clkIn) begin
    if (bus.addValidOut || bus.delValidOut || bus.execValidOut) begin
      chk("onehot", 64'($countones({bus.addValidOut, bus.delValidOut, bus.execValidOut})), 64'd1);
      if (sb.size() == 0) begin
        chk("unexp_pulse", {61'd0, bus.addValidOut, bus.delValidOut, bus.execValidOut}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("kind",   {61'd0, bus.addValidOut, bus.delValidOut, bus.execValidOut}, {61'd0, mon_e.kind});
        chk("refNum", bus.refNumOut, mon_e.rn);
        chk("locate", {48'd0, bus.locateOut}, {48'd0, mon_e.loc});
        chk("price",  {32'd0, bus.priceOut}, {32'd0, mon_e.prc});
        chk("shares", {32'd0, bus.sharesOut}, {32'd0, mon_e.shr});
        chk("side",   {63'd0, bus.buySellOut}, {63'd0, mon_e.side});
      end
    end
  end

  task automatic cyc();
    @(posedge clkIn);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gapmax);
    int g;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    bus.dataValidIn = 1'b0;
    bus.dataLastIn  = 1'b0;
    repeat (g) cyc();
    bus.dataIn      = b;
    bus.dataValidIn = 1'b1;
    bus.dataLastIn  = last;
    cyc();
    bus.dataValidIn = 1'b0;
    bus.dataLastIn  = 1'b0;
  endtask

  task automatic fill(input logic [7:0] t, input logic [15:0] loc, input logic [63:0] rn,
                      input logic [7:0] side, input logic [31:0] shr, input logic [31:0] prc);
    for (int i = 0; i < 64; i++) mbuf[i] = 8'($urandom);
    mbuf[0] = t;
    mbuf[1] = loc[15:8];
    mbuf[2] = loc[7:0];
    for (int k = 0; k < 8; k++) mbuf[11+k] = rn[63-8*k -: 8];
    if (t == 8'h41 || t == 8'h46) begin
      mbuf[19] = side;
      for (int k = 0; k < 4; k++) begin
        mbuf[20+k] = shr[31-8*k -: 8];
        mbuf[32+k] = prc[31-8*k -: 8];
      end
    end else if (t == 8'h45) begin
      for (int k = 0; k < 4; k++) mbuf[19+k] = shr[31-8*k -: 8];
    end
  endtask

  // Header plus message bytes; dataLastIn rides on byte last_at, which ends the send
  task automatic send_msg(input int len, input int last_at, input int gapmax);
    send_byte(8'(len >> 8), 1'b0, gapmax);
    send_byte(8'(len), 1'b0, gapmax);
    for (int i = 0; i < len; i++) begin
      send_byte(mbuf[i], (i == last_at), gapmax);
      if (i == last_at) break;
    end
  endtask

  task automatic push_ev(input logic [2:0] kind, input logic [63:0] rn, input logic [15:0] loc,
                         input logic [31:0] prc, input logic [31:0] shr, input logic side);
    ev_t e;
    e.kind = kind; e.rn = rn; e.loc = loc; e.prc = prc; e.shr = shr; e.side = side;
    sb.push_back(e);
  endtask

  task automatic chk_pulse(input string tag, input logic [2:0] exp3);
    chk(tag, {61'd0, bus.addValidOut, bus.delValidOut, bus.execValidOut}, {61'd0, exp3});
  endtask

  task automatic chk_err(input string tag);
    chk(tag, {48'd0, bus.errCountOut}, 64'(exp_err));
  endtask

  task automatic chk_all_zero(input string tag);
    chk_pulse({tag, "_pulse"}, K_NONE);
    chk({tag, "_ref"},   bus.refNumOut, 64'd0);
    chk({tag, "_loc"},   {48'd0, bus.locateOut}, 64'd0);
    chk({tag, "_price"}, {32'd0, bus.priceOut}, 64'd0);
    chk({tag, "_shr"},   {32'd0, bus.sharesOut}, 64'd0);
    chk({tag, "_side"},  {63'd0, bus.buySellOut}, 64'd0);
    chk({tag, "_err"},   {48'd0, bus.errCountOut}, 64'd0);
  endtask

  task automatic err_bump();
    if (exp_err < 65535) exp_err++;
  endtask

  initial begin
    int n_a;
    bus.dataIn = 8'h00; bus.dataValidIn = 1'b0; bus.dataLastIn = 1'b0;
    rstIn = 1'b0;
    repeat (3) cyc();
    chk_all_zero("reset");
    rstIn = 1'b1;
    cyc();

    // Add 'A', buy side
    fill(8'h41, 16'h0012, 64'h0000_0000_00AB_CDEF, 8'h42, 32'd100, 32'h0001_E240);
    push_ev(K_ADD, 64'h0000_0000_00AB_CDEF, 16'h0012, 32'h0001_E240, 32'd100, 1'b1);
    send_msg(36, 35, 0);
    chk_pulse("add1_lat", K_ADD);

    // Delete then Exec on the same ref, back to back
    fill(8'h44, 16'h0034, 64'h1122_3344_5566_7788, 8'h00, 32'd0, 32'd0);
    push_ev(K_DEL, 64'h1122_3344_5566_7788, 16'h0034, 32'd0, 32'd0, 1'b0);
    send_msg(19, 18, 0);
    chk_pulse("del1_lat", K_DEL);
    fill(8'h45, 16'h0034, 64'h1122_3344_5566_7788, 8'h00, 32'd50, 32'd0);
    push_ev(K_EXEC, 64'h1122_3344_5566_7788, 16'h0034, 32'd0, 32'd50, 1'b0);
    send_msg(31, 30, 0);
    chk_pulse("exec1_lat", K_EXEC);
    chk_err("err_after_exec");

    // Unknown 'S' skipped, then a sell-side add, then an MPID add
    fill(8'h53, 16'h0001, 64'd0, 8'h00, 32'd0, 32'd0);
    send_msg(12, 11, 0);
    chk_pulse("unk_pulse", K_NONE);
    fill(8'h41, 16'hBEEF, 64'h0102_0304_0506_0708, 8'h53, 32'd7, 32'h0011_2233);
    push_ev(K_ADD, 64'h0102_0304_0506_0708, 16'hBEEF, 32'h0011_2233, 32'd7, 1'b0);
    send_msg(36, 35, 0);
    chk_pulse("add2_lat", K_ADD);
    chk_err("err_after_unk");
    fill(8'h46, 16'h00FF, 64'hFEDC_BA98_7654_3210, 8'h42, 32'd500, 32'd999);
    push_ev(K_ADD, 64'hFEDC_BA98_7654_3210, 16'h00FF, 32'd999, 32'd500, 1'b1);
    send_msg(40, 39, 0);
    chk_pulse("addf_lat", K_ADD);

    // Add with wrong length
    fill(8'h41, 16'h0005, 64'h55, 8'h42, 32'd1, 32'd1);
    send_msg(30, 29, 0);
    chk_pulse("badlen_pulse", K_NONE);
    err_bump();
    chk_err("err_badlen");

    // Truncated add (dataLastIn on byte 10), then a clean delete
    fill(8'h41, 16'h0006, 64'h66, 8'h42, 32'd2, 32'd2);
    send_msg(36, 10, 0);
    chk_pulse("trunc_pulse", K_NONE);
    err_bump();
    chk_err("err_trunc");
    fill(8'h44, 16'h0A0B, 64'hDEAD_BEEF_0000_0001, 8'h00, 32'd0, 32'd0);
    push_ev(K_DEL, 64'hDEAD_BEEF_0000_0001, 16'h0A0B, 32'd0, 32'd0, 1'b0);
    send_msg(19, 18, 0);
    chk_pulse("del2_lat", K_DEL);

    // Add with random stalls
    fill(8'h41, 16'h0777, 64'hA5A5_5A5A_0F0F_F0F0, 8'h42, 32'd1234, 32'h7FFF_FFFF);
    push_ev(K_ADD, 64'hA5A5_5A5A_0F0F_F0F0, 16'h0777, 32'h7FFF_FFFF, 32'd1234, 1'b1);
    send_msg(36, 35, 5);
    chk_pulse("add_gap_lat", K_ADD);

    // Reset partway through a second add
    fill(8'h41, 16'h0888, 64'h99, 8'h42, 32'd3, 32'd3);
    send_byte(8'h00, 1'b0, 3);
    send_byte(8'd36, 1'b0, 3);
    for (int i = 0; i < 20; i++) send_byte(mbuf[i], 1'b0, 3);
    rstIn = 1'b0;
    cyc();
    cyc();
    chk_all_zero("midrst");
    rstIn = 1'b1;
    exp_err = 0;
    cyc();
    fill(8'h44, 16'h0C0D, 64'h0BAD_F00D_1234_5678, 8'h00, 32'd0, 32'd0);
    push_ev(K_DEL, 64'h0BAD_F00D_1234_5678, 16'h0C0D, 32'd0, 32'd0, 1'b0);
    send_msg(19, 18, 0);
    chk_pulse("del3_lat", K_DEL);

    // Reset arriving with the final byte of an add suppresses its pulse
    fill(8'h41, 16'h0999, 64'h77, 8'h42, 32'd4, 32'd4);
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'd36, 1'b0, 0);
    for (int i = 0; i < 35; i++) send_byte(mbuf[i], 1'b0, 0);
    bus.dataIn = mbuf[35]; bus.dataValidIn = 1'b1; bus.dataLastIn = 1'b1;
    rstIn = 1'b0;
    cyc();
    bus.dataValidIn = 1'b0; bus.dataLastIn = 1'b0;
    chk_pulse("rst_suppress", K_NONE);
    rstIn = 1'b1;
    cyc();

    // Zero-length block then a delete
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h00, 1'b0, 0);
    chk_pulse("zero_len_pulse", K_NONE);
    chk_err("err_zero_len");
    fill(8'h44, 16'h0E0F, 64'h0000_0000_0000_0042, 8'h00, 32'd0, 32'd0);
    push_ev(K_DEL, 64'h0000_0000_0000_0042, 16'h0E0F, 32'd0, 32'd0, 1'b0);
    send_msg(19, 18, 0);
    chk_pulse("del4_lat", K_DEL);
    chk_err("err_after_zero");

    // 70000 single-byte truncated payloads drive the error counter into saturation
    n_a = 65534 - exp_err;
    bus.dataIn = 8'h00; bus.dataValidIn = 1'b1; bus.dataLastIn = 1'b1;
    repeat (n_a) cyc();
    bus.dataValidIn = 1'b0; bus.dataLastIn = 1'b0;
    for (int i = 0; i < n_a; i++) err_bump();
    chk_err("err_near_max");
    bus.dataValidIn = 1'b1; bus.dataLastIn = 1'b1;
    repeat (70000 - n_a) cyc();
    bus.dataValidIn = 1'b0; bus.dataLastIn = 1'b0;
    for (int i = 0; i < 70000 - n_a; i++) err_bump();
    chk_err("err_saturated");
    chk({48'd0, bus.errCountOut}, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_FFFF) ;

    fill(8'h44, 16'h1111, 64'h2222_3333_4444_5555, 8'h00, 32'd0, 32'd0);
    push_ev(K_DEL, 64'h2222_3333_4444_5555, 16'h1111, 32'd0, 32'd0, 1'b0);
    send_msg(19, 18, 0);
    chk_pulse("del5_lat", K_DEL);
    cyc();
    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/itch_order_parser.md
# itch_order_parser

Parses the ITCH 5.0 message-block byte stream carried in each MoldUDP64 payload and extracts Add Order, Order Delete and Order Executed events. It is the producer side of the order map's add/delete/execute interface. It drives the one-cycle valid pulses and the refNum/locate/price/shares/side fields that the order map consumes. Other ITCH message types are skipped without side effects.

## Interface
- ERR_CNT_WIDTH, 16, width of the saturating error counter.
- SUPPORT_MPID, 1, when 1, type 'F' (Add Order with MPID) is decoded as an add; when 0, it is skipped as unknown.

- clkIn  input  1  system clock; all logic on the rising edge.
- rstIn  input  1  synchronous, active-low reset.
- dataIn  input  8  payload byte, network (big-endian) order.
- dataValidIn  input  1  dataIn is valid this cycle; when low, the parser stalls and holds all state.
- dataLastIn  input  1  qualifies the final byte of the UDP payload; only meaningful with dataValidIn.
- addValidOut  output  1  one-cycle pulse: add order decoded.
- delValidOut  output  1  one-cycle pulse: order delete decoded.
- execValidOut  output  1  one-cycle pulse: order executed decoded.
- refNumOut  output  64  order reference number.
- locateOut  output  16  stock locate.
- priceOut  output  32  price (add only, else 0).
- sharesOut  output  32  shares (add) or executed shares (exec), else 0.
- buySellOut  output  1  1 = 'B' (0x42), 0 = any other side byte (add only, else 0).
- errCountOut  output  ERR_CNT_WIDTH  count of dropped malformed messages; saturates at all ones.

## Operation
- Stream format: repeated blocks of {2-byte big-endian length L, L message bytes}. Byte 0 of the message is the type.
- FSM states:
  - LEN_HI: capture length[15:8]; go to LEN_LO.
  - LEN_LO: capture length[7:0]. If L == 0, go to LEN_HI with no error. Otherwise go to MSG.
  - MSG: byte counter idx runs from 0 to L-1. Byte 0 latches the type; later bytes load fields by offset. After byte L-1, go to LEN_HI.
- Field offsets, all types: locate at bytes 1–2, refNum at bytes 11–18.
- Add 'A' (0x41, L = 36) and 'F' (0x46, L = 40): side at byte 19, shares at bytes 20–23, price at bytes 32–35.
- Exec 'E' (0x45, L = 31): shares at bytes 19–22.
- Delete 'D' (0x44, L = 19): no further fields.
- Message outcome, checked at the last byte:
  - Known type with L equal to its expected length: emit the matching pulse.
  - Known type with a wrong L: consume all L bytes, emit nothing, errCount++.
  - Unknown type: consume L bytes silently, no error.
- Shadow registers:
  - Fields are captured into shadow registers.
  - Output field registers load from the shadows only in the cycle the pulse is asserted.
  - Fields not used by the message type load 0.
  - Outputs hold their values between pulses.
- At most one of add/del/exec is high in any cycle.
- dataLastIn asserted:
  - In MSG on byte L-1: normal completion, then go to LEN_HI.
  - In LEN_HI, LEN_LO, or MSG before byte L-1: truncated. Emit nothing, errCount++, go to LEN_HI.
  - Always: the next valid byte is treated as LEN_HI of a new payload.
- Width rules:
  - The idx counter is 16 bits, so L up to 65535 never wraps.
  - The error counter does not wrap; it holds at max.

## Timing
- Latency: the pulse and updated fields are registered outputs, valid exactly 1 cycle after the clock edge that accepts message byte L-1.
- No backpressure; the parser accepts one byte per dataValidIn cycle.
- Minimum gap between pulses is 21 cycles (a 2-byte header plus a 19-byte delete), so pulses never overlap.
- Stall: dataValidIn gaps of any length delay the pulse by the gap; there is no timeout.
- Reset: while rstIn == 0, all outputs, errCountOut, shadow registers, idx and the type latch are 0, and the state is LEN_HI.
- Reset mid-message discards the partial message with no error count.
- A pulse due in the cycle reset asserts is suppressed.

## Structure
- Add the following to pkg:
  - ITCH type constants ITCH_ADD, ITCH_ADD_MPID, ITCH_DEL, ITCH_EXEC.
  - Expected lengths ITCH_ADD_LEN = 36, ITCH_ADD_MPID_LEN = 40, ITCH_DEL_LEN = 19, ITCH_EXEC_LEN = 31.
  - Field offset constants.
  - Enum parserStateType {LEN_HI, LEN_LO, MSG}.
- Single module, no new sub-module. Field capture is an offset-indexed shift into the shadow registers inside the FSM process.

## Test plan
- Add 'A' with L = 36, locate 0x0012, ref 0x0000000000ABCDEF, side 'B', shares 100, price 0x0001E240 -> one addValidOut pulse 1 cycle after byte 35 with exactly those field values.
- Delete 'D' with L = 19, ref 0x1122334455667788, then Exec 'E' with L = 31, same ref, shares 50, back to back -> delValidOut with price/shares/side 0, then execValidOut with sharesOut = 50; errCountOut stays 0.
- Unknown type 'S' with L = 12, then an 'A' message -> only the add pulse fires; errCountOut stays 0. Then an 'A' with L = 30 -> no pulse, errCountOut = 1.
- dataLastIn on byte 10 of an Add -> no pulse, errCountOut increments. The next payload's Delete decodes correctly.
- Random dataValidIn gaps of 0–5 cycles inside an Add, with a reset asserted midway through a second Add -> the first add decodes correctly; outputs read 0 during reset; after reset, a Delete decodes correctly.
- L = 0 block followed by a Delete; and 70,000 malformed messages -> the zero-length block produces no pulse and no error; errCountOut saturates at 0xFFFF.
